// File: rtl/sccb_wr_master.sv
// SCCB 3-phase write master: START, {dev,0}, addr_hi, addr_lo, data, STOP.
// Define SCCB_ACK_CHECK_EN to abort on a NACKed byte and flag ack_err.
module sccb_wr_master #(
  parameter logic [6:0] DEVICE_ADDR  = 7'h3C,
  parameter int         SYS_CLK_FREQ = 50_000_000,
  parameter int         SCL_FREQ     = 250_000,
  parameter int         CNT_QTR      = SYS_CLK_FREQ / (SCL_FREQ * 4)
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        cfg_start,
  input  logic [23:0] cfg_data,
  output logic        cfg_end,
  output logic        busy,
  output logic        ack_err,
  output logic        sccb_scl,
  inout  wire         sccb_sda
);

  localparam int QW = (CNT_QTR > 2) ? $clog2(CNT_QTR) : 1;

  typedef enum logic [2:0] {
    IDLE, START, BIT, ACK, STOP, DONE
  } state_t;

  state_t        state_q, state_d;
  logic [QW-1:0] qcnt_q, qcnt_d;
  logic [1:0]    ph_q, ph_d;
  logic [2:0]    bitcnt_q, bitcnt_d;
  logic [1:0]    bytecnt_q, bytecnt_d;
  logic [31:0]   shift_q, shift_d;
  logic          scl_q, scl_d;
  logic          sda_oe_q, sda_oe_d;
  logic          cfg_end_q, cfg_end_d;
  logic          busy_q, busy_d;
  logic          ack_err_q, ack_err_d;
  logic          q_tick;
  logic          slot_end;
  logic          last_byte;

  assign q_tick   = (qcnt_q == QW'(CNT_QTR - 1));
  assign slot_end = q_tick && (ph_q == 2'd3);

`ifdef SCCB_ACK_CHECK_EN
  assign last_byte = (bytecnt_q == 2'd3) || ack_err_q;
`else
  assign last_byte = (bytecnt_q == 2'd3);
`endif

  always_comb begin
    state_d   = state_q;
    qcnt_d    = qcnt_q;
    ph_d      = ph_q;
    bitcnt_d  = bitcnt_q;
    bytecnt_d = bytecnt_q;
    shift_d   = shift_q;
    cfg_end_d = 1'b0;
    busy_d    = busy_q;
    ack_err_d = ack_err_q;

    if (state_q != IDLE && state_q != DONE) begin
      qcnt_d = q_tick ? '0 : qcnt_q + 1'b1;
      if (q_tick)
        ph_d = ph_q + 2'd1;
    end

    unique case (state_q)
      IDLE: begin
        if (cfg_start) begin
          shift_d   = {DEVICE_ADDR, 1'b0, cfg_data};
          busy_d    = 1'b1;
          qcnt_d    = '0;
          ph_d      = 2'd0;
          ack_err_d = 1'b0;
          state_d   = START;
        end
      end
      START: begin
        if (slot_end) begin
          bitcnt_d  = 3'd7;
          bytecnt_d = 2'd0;
          state_d   = BIT;
        end
      end
      BIT: begin
        if (slot_end) begin
          shift_d = {shift_q[30:0], 1'b0};
          if (bitcnt_q == 3'd0)
            state_d = ACK;
          else
            bitcnt_d = bitcnt_q - 3'd1;
        end
      end
      ACK: begin
`ifdef SCCB_ACK_CHECK_EN
        if (q_tick && ph_q == 2'd2 && sccb_sda !== 1'b0)
          ack_err_d = 1'b1;
`endif
        if (slot_end) begin
          if (last_byte) begin
            state_d = STOP;
          end else begin
            bytecnt_d = bytecnt_q + 2'd1;
            bitcnt_d  = 3'd7;
            state_d   = BIT;
          end
        end
      end
      STOP: begin
        if (slot_end) begin
          cfg_end_d = 1'b1;
          state_d   = DONE;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Bus levels are registered from the upcoming state/phase.
    scl_d    = 1'b1;
    sda_oe_d = 1'b0;
    unique case (state_d)
      START: begin
        scl_d    = (ph_d != 2'd3);
        sda_oe_d = ph_d[1];
      end
      BIT: begin
        scl_d    = ph_d[0] ^ ph_d[1];
        sda_oe_d = ~shift_d[31];
      end
      ACK: scl_d = ph_d[0] ^ ph_d[1];
      STOP: begin
        scl_d    = (ph_d != 2'd0);
        sda_oe_d = ~ph_d[1];
      end
      default: begin
        scl_d    = 1'b1;
        sda_oe_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= IDLE;
      qcnt_q    <= '0;
      ph_q      <= 2'd0;
      bitcnt_q  <= 3'd0;
      bytecnt_q <= 2'd0;
      shift_q   <= '0;
      scl_q     <= 1'b1;
      sda_oe_q  <= 1'b0;
      cfg_end_q <= 1'b0;
      busy_q    <= 1'b0;
      ack_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      qcnt_q    <= qcnt_d;
      ph_q      <= ph_d;
      bitcnt_q  <= bitcnt_d;
      bytecnt_q <= bytecnt_d;
      shift_q   <= shift_d;
      scl_q     <= scl_d;
      sda_oe_q  <= sda_oe_d;
      cfg_end_q <= cfg_end_d;
      busy_q    <= busy_d;
      ack_err_q <= ack_err_d;
    end
  end

  assign cfg_end  = cfg_end_q;
  assign busy     = busy_q;
  assign ack_err  = ack_err_q;
  assign sccb_scl = scl_q;
  assign sccb_sda = sda_oe_q ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_sccb_wr_master.sv
// Scoreboard bench for sccb_wr_master: bus decoder + ACKing slave model.
// Expected bus events are queued by stimulus and popped by the monitor.
module tb_sccb_wr_master;

  localparam int Q    = 50;
  localparam int FULL = 152 * Q + 1;
  localparam int K_BYTE = 0, K_START = 1, K_STOP = 2, K_END = 3;

  typedef struct {
    int kind;
    int val;
  } ev_t;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        cfg_start = 1'b0;
  logic [23:0] cfg_data = 24'h0;
  logic        cfg_end, busy, ack_err, sccb_scl;
  wire         sccb_sda;
  logic        slv_drv = 1'b0;

  assign sccb_sda = slv_drv ? 1'b0 : 1'bz;
  pullup (sccb_sda);

  sccb_wr_master dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .cfg_start (cfg_start),
    .cfg_data  (cfg_data),
    .cfg_end   (cfg_end),
    .busy      (busy),
    .ack_err   (ack_err),
    .sccb_scl  (sccb_scl),
    .sccb_sda  (sccb_sda)
  );

  always #10 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  int   checks = 0, failures = 0;
  ev_t  exp_q[$];
  logic mon_en = 1'b0;
  int   nack_idx = -1;
  int   bstart = 1, bend = 0;
  int   bytes_seen = 0;
  int   bad_edges = 0, bad_per = 0, nper = 0, busy_err = 0;

  task automatic push_ev(input int k, input int v);
    ev_t e;
    e.kind = k;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  task automatic push_frame(input logic [23:0] d);
    push_ev(K_START, 0);
    push_ev(K_BYTE, 32'h78);
    push_ev(K_BYTE, int'(d[23:16]));
    push_ev(K_BYTE, int'(d[15:8]));
    push_ev(K_BYTE, int'(d[7:0]));
    push_ev(K_STOP, 0);
  endtask

  task automatic got(input int k, input int v);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL bus_event unexpected kind=%0d val=%0h required none", k, v);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.val != v) begin
        failures++;
        $display("FAIL bus_event got kind=%0d val=%0h required kind=%0d val=%0h",
                 k, v, e.kind, e.val);
      end
    end
  endtask

  task automatic chk(input string n, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s got=%0h required=%0h", n, act, req);
    end
  endtask

  task automatic start_cfg(input logic [23:0] d, input int dur, input bit want_end);
    @(posedge sys_clk);
    #1;
    cfg_start = 1'b1;
    cfg_data  = d;
    @(negedge sys_clk);
    if (dur > 0) begin
      bstart = cyc + 1;
      bend   = cyc + dur;
      if (want_end)
        push_ev(K_END, cyc + dur);
    end
    @(posedge sys_clk);
    #1;
    cfg_start = 1'b0;
    cfg_data  = ~d;
  endtask

  task automatic wait_end();
    int n;
    n = 0;
    while (cfg_end !== 1'b1 && n < 20000) begin
      @(negedge sys_clk);
      n++;
    end
    if (cfg_end !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL wait_end timeout got cfg_end=%b required 1", cfg_end);
    end
  endtask

  // Bus decoder, slave ACK model, SDA-edge and SCL-period checker.
  initial begin
    logic pscl, psda, scl, sda;
    int   bitn, sbyte, last_rise;
    logic [8:0] sh;
    pscl = 1'b1; psda = 1'b1; bitn = 0; sbyte = 0; last_rise = -1; sh = '0;
    forever begin
      @(negedge sys_clk);
      scl = sccb_scl;
      sda = sccb_sda;
      if (!mon_en) begin
        bitn      = 0;
        last_rise = -1;
        slv_drv   = 1'b0;
      end else begin
        if (busy !== ((cyc >= bstart) && (cyc <= bend)))
          busy_err++;
        if (sda != psda) begin
          if (pscl && scl) begin
            if (!sda) begin
              got(K_START, 0);
              bitn = 0; sbyte = 0; last_rise = -1;
            end else begin
              got(K_STOP, 0);
            end
          end else if (pscl || scl) begin
            bad_edges++;
          end
        end
        if (!pscl && scl) begin
          if (last_rise >= 0) begin
            nper++;
            if (cyc - last_rise != 4 * Q)
              bad_per++;
          end
          last_rise = cyc;
          sh = {sh[7:0], sda};
          bitn++;
          if (bitn == 9) begin
            got(K_BYTE, int'(sh[8:1]));
            bitn = 0;
            sbyte++;
            bytes_seen++;
          end
        end
        if (pscl && !scl)
          slv_drv = (bitn == 8) && (sbyte != nack_idx);
        if (cfg_end === 1'b1)
          got(K_END, cyc);
      end
      pscl = scl;
      psda = sda;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout required finish");
    $fatal(1);
  end

  initial begin
    int nb, n;
    @(negedge sys_clk);
    chk("rst_cfg_end", int'(cfg_end), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ack_err", int'(ack_err), 0);
    chk("rst_scl", int'(sccb_scl), 1);
    chk("rst_sda", int'(sccb_sda), 1);
    repeat (2) @(posedge sys_clk);
    #1 sys_rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);
    mon_en = 1'b1;

    // Frame, with an ignored request 100 cycles in.
    push_frame(24'h300842);
    start_cfg(24'h300842, FULL, 1'b1);
    repeat (100) @(posedge sys_clk);
    start_cfg(24'h310303, 0, 1'b0);
    wait_end();

    // Back-to-back request right after cfg_end.
    push_frame(24'h3008FF);
    start_cfg(24'h3008FF, FULL, 1'b1);
    wait_end();

    // Reset during the third byte.
    push_ev(K_START, 0);
    push_ev(K_BYTE, 32'h78);
    push_ev(K_BYTE, 32'h30);
    nb = bytes_seen;
    start_cfg(24'h300842, 1_000_000, 1'b0);
    n = 0;
    while (bytes_seen < nb + 2 && n < 20000) begin
      @(negedge sys_clk);
      n++;
    end
    chk("abort_bytes_seen", bytes_seen - nb, 2);
    repeat (400) @(posedge sys_clk);
    #5;
    mon_en = 1'b0;
    sys_rst_n = 1'b0;
    bend = 0;
    #1;
    chk("abort_scl", int'(sccb_scl), 1);
    chk("abort_sda", int'(sccb_sda), 1);
    chk("abort_busy", int'(busy), 0);
    chk("abort_cfg_end", int'(cfg_end), 0);
    repeat (3) @(posedge sys_clk);
    #1 sys_rst_n = 1'b1;
    repeat (3) @(negedge sys_clk);
    chk("abort_queue", exp_q.size(), 0);
    mon_en = 1'b1;
    push_frame(24'h300842);
    start_cfg(24'h300842, FULL, 1'b1);
    wait_end();

    // Slave NACKs byte 1.
    nack_idx = 1;
`ifdef SCCB_ACK_CHECK_EN
    push_ev(K_START, 0);
    push_ev(K_BYTE, 32'h78);
    push_ev(K_BYTE, 32'h30);
    push_ev(K_STOP, 0);
    start_cfg(24'h300842, 80 * Q + 1, 1'b1);
    wait_end();
    chk("nack_ack_err", int'(ack_err), 1);
`else
    push_frame(24'h300842);
    start_cfg(24'h300842, FULL, 1'b1);
    wait_end();
    chk("nack_ack_err", int'(ack_err), 0);
`endif
    nack_idx = -1;

    // Next accepted request clears the flag.
    push_frame(24'h310303);
    start_cfg(24'h310303, FULL, 1'b1);
    repeat (5) @(negedge sys_clk);
    chk("ack_err_cleared", int'(ack_err), 0);
    wait_end();

    repeat (10) @(negedge sys_clk);
    chk("queue_empty", exp_q.size(), 0);
    chk("sda_edges_scl_high", bad_edges, 0);
    chk("scl_period", bad_per, 0);
    chk("scl_periods_seen", int'(nper > 0), 1);
    chk("busy_window", busy_err, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sccb_wr_master.md
Name: sccb_wr_master

Overview:
- SCCB/I2C write master that sits directly downstream of the OV5640 register-configuration sequencer.
- Accepts one `cfg_start` pulse with a 24-bit `{reg_addr[15:0], reg_val[7:0]}` word.
- Serialises a 4-byte SCCB write to the camera (device address, address high byte, address low byte, data byte), then returns a one-cycle `cfg_end` pulse so the sequencer advances to the next table entry.

Parameters:
- `DEVICE_ADDR`, 7'h3C, 7-bit SCCB slave address; the write phase byte is `{DEVICE_ADDR, 1'b0}` = 8'h78.
- `SYS_CLK_FREQ`, 50_000_000, `sys_clk` frequency in Hz.
- `SCL_FREQ`, 250_000, target SCL frequency in Hz.
- `CNT_QTR`, `SYS_CLK_FREQ/(SCL_FREQ*4)` (= 50), `sys_clk` cycles per quarter SCL period; must be ≥ 2.

Ports:
- `sys_clk`, input, 1: system clock.
- `sys_rst_n`, input, 1: asynchronous, active-low reset.
- `cfg_start`, input, 1: single-cycle transaction request.
- `cfg_data`, input, 24: `{reg_addr[15:0], reg_val[7:0]}`; captured on the `cfg_start` cycle.
- `cfg_end`, output, 1: single-cycle pulse marking transaction complete.
- `busy`, output, 1: high from the capture cycle until `cfg_end`, inclusive.
- `ack_err`, output, 1: NACK flag; see Optional Feature.
- `sccb_scl`, output, 1: SCCB clock, push-pull.
- `sccb_sda`, inout, 1: SCCB data, open-drain; the block drives 0 or 'z' only.

Behaviour:
Reset:
- `sys_rst_n` low (asynchronous) → state IDLE.
- `cfg_end` = 0, `busy` = 0, `ack_err` = 0, `sccb_scl` = 1, `sccb_sda` = 'z', all counters 0.

Quarter timebase:
- `qcnt` counts 0..`CNT_QTR`-1 while not IDLE.
- `q_tick` asserts at `qcnt` == `CNT_QTR`-1.
- Phase counter `ph[1:0]` advances on each `q_tick`.

States:
- IDLE:
  - `sccb_scl` = 1, SDA released.
  - `cfg_start` = 1 → latch `shift` = `{DEVICE_ADDR, 0, cfg_data}` (32 bits), `busy` = 1, go to START.
  - `cfg_start` while `busy` = 1 is ignored (no queueing).
- START (4 quarters):
  - ph0/ph1: SCL = 1, SDA released.
  - ph2: SDA = 0.
  - ph3: SCL = 0.
  - Then go to BIT, with `bitcnt` = 7 and `bytecnt` = 0.
- BIT (4 quarters per bit, MSB first):
  - ph0: SCL = 0; drive SDA = 0 if `shift[31]` = 0, else release.
  - ph1: SCL = 1.
  - ph2: SCL = 1, hold.
  - ph3: SCL = 0, shift left.
  - After `bitcnt` = 0 → go to ACK.
- ACK (4 quarters):
  - SDA released throughout; SCL follows the same ph pattern as BIT.
  - `sccb_sda` is sampled at the end of ph2.
  - If `bytecnt` == 3 → go to STOP; else increment `bytecnt`, set `bitcnt` = 7, go to BIT.
- STOP (4 quarters):
  - ph0: SCL = 0, SDA = 0.
  - ph1: SCL = 1.
  - ph2: SDA released (STOP condition).
  - ph3: idle levels.
- DONE (1 cycle):
  - `cfg_end` = 1 for exactly one cycle.
  - `busy` drops on the following cycle; return to IDLE.

Timing:
- Transaction length = 152 quarters: START 4 + 4 bytes × 9 slots × 4 + STOP 4.
- With `cfg_start` sampled at edge N, `cfg_end` is high in cycle N + 1 + 152·`CNT_QTR` (7601 cycles at defaults).
- A `cfg_start` coincident with `cfg_end`/DONE is ignored. A new `cfg_start` is accepted from the first IDLE cycle onward (the upstream sequencer registers its start one cycle after `cfg_end`).

Other rules:
- SDA transitions only while SCL = 0, except for the START and STOP edges.
- Reset mid-transaction: immediate return to idle bus levels; no `cfg_end` pulse.
- `cfg_data` changes after capture have no effect.

Optional Feature:
Macro `SCCB_ACK_CHECK_EN`.
- Defined:
  - A sampled ACK bit = 1 (NACK) sets `ack_err` = 1 and skips the remaining bytes straight to STOP.
  - `cfg_end` still pulses, so the sequencer does not hang.
  - `ack_err` is cleared on the next accepted `cfg_start`.
- Undefined:
  - ACK slot value is don't-care per SCCB; `ack_err` is tied to 0.
  - Transaction always runs the full 152 quarters.

Test Plan:
1. Reset, then `cfg_start` with `cfg_data` = 24'h300842 → bus model decodes START, 0x78, 0x30, 0x08, 0x42, STOP. `cfg_end` pulses once, 7601 cycles after `cfg_start`; `busy` is high throughout.
2. Second `cfg_start` pulse 100 cycles into a transaction with 24'h310303 → ignored; bus shows only the first frame and a single `cfg_end`.
3. Checker on every SDA edge → SDA edges occur only with SCL = 0, apart from one START falling edge and one STOP rising edge per frame; SCL period is 200 cycles.
4. Back-to-back: `cfg_start` one cycle after `cfg_end`, data 24'h3008FF → accepted; frame bytes are 0x78, 0x30, 0x08, 0xFF.
5. Assert `sys_rst_n` = 0 during byte 2 → `sccb_scl` = 1 and `sccb_sda` = 'z' immediately; no `cfg_end`. The next `cfg_start` produces a complete clean frame.
6. With `SCCB_ACK_CHECK_EN` defined and the slave NACKing byte 1 (0x30) → `ack_err` = 1, STOP follows that ACK slot, `cfg_end` pulses. Without the macro the same stimulus gives the full frame and `ack_err` = 0.
